// File: rtl/guarded_array_rf.sv
// guarded_array_rf: small register file with per-entry override and index guarding.
// Legal indices are BASE..BASE+DEPTH-1. Writes, override sets and override clears
// to illegal indices change no state and are counted in a saturating error counter
// with a sticky error flag. A read to an illegal index returns zero.
// Optional feature: define GUARDED_RF_XCHECK_EN to treat any index that contains
// X/Z bits as illegal. Without it only the range check is made.
module guarded_array_rf #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int BASE  = 1,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ovr_set,
  input  logic             ovr_clr,
  input  logic [IDX_W-1:0] ovr_idx,
  input  logic [WIDTH-1:0] ovr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ovr,
  output logic             err_flag,
  output logic [7:0]       err_cnt
);

  // Range bounds kept 32 bits wide so the compare never truncates.
  localparam logic [31:0] LO = 32'(BASE);
  localparam logic [31:0] HI = 32'(BASE + DEPTH - 1);

  // True when idx names a real entry.
  function automatic logic idx_legal(input logic [IDX_W-1:0] idx);
    logic ok;
    ok = (32'(idx) >= LO) && (32'(idx) <= HI);
`ifdef GUARDED_RF_XCHECK_EN
    if ($isunknown(idx)) ok = 1'b0;
`endif
    return ok;
  endfunction

  // True when idx addresses entry number ent (0-based).
  function automatic logic idx_hit(input logic [IDX_W-1:0] idx, input int ent);
    return 32'(idx) == (LO + 32'(ent));
  endfunction

  logic [WIDTH-1:0] storage [DEPTH];
  logic             ovr_bit [DEPTH];
  logic [WIDTH-1:0] ovr_val [DEPTH];

  logic [WIDTH-1:0] nxt_storage [DEPTH];
  logic             nxt_ovr_bit [DEPTH];
  logic [WIDTH-1:0] nxt_ovr_val [DEPTH];
  logic [WIDTH-1:0] nxt_rd_data;
  logic             nxt_rd_ovr;

  logic             wr_legal, set_legal, clr_legal;
  logic             wr_ok, set_ok, clr_ok;
  logic [1:0]       n_err;
  logic [8:0]       err_sum;
  logic [7:0]       nxt_err_cnt;

  // Next entry state, registered read value and error accounting for this edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nxt_storage = storage;
    nxt_ovr_bit = ovr_bit;
    nxt_ovr_val = ovr_val;
    nxt_rd_data = '0;
    nxt_rd_ovr  = 1'b0;

    wr_legal  = idx_legal(wr_idx);
    set_legal = idx_legal(ovr_idx);
    clr_legal = set_legal;
    wr_ok     = wr_en   && wr_legal;
    set_ok    = ovr_set && set_legal;
    clr_ok    = ovr_clr && clr_legal;

    for (int i = 0; i < DEPTH; i++) begin
      // Set and clear share one index; set wins when both are asserted.
      if (set_ok && idx_hit(ovr_idx, i)) begin
        nxt_ovr_bit[i] = 1'b1;
        nxt_ovr_val[i] = ovr_data;
      end else if (clr_ok && idx_hit(ovr_idx, i)) begin
        nxt_ovr_bit[i] = 1'b0;
        nxt_storage[i] = ovr_val[i];
      end
      // A write lands after the clear copy so it takes precedence on storage.
      if (wr_ok && idx_hit(wr_idx, i)) begin
        nxt_storage[i] = wr_data;
      end
    end

    // Read sees the entry as it will be after this edge.
    if (idx_legal(rd_idx)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (idx_hit(rd_idx, i)) begin
          nxt_rd_ovr  = nxt_ovr_bit[i];
          nxt_rd_data = nxt_ovr_bit[i] ? nxt_ovr_val[i] : nxt_storage[i];
        end
      end
    end

    n_err = {1'b0, wr_en   && !wr_legal}
          + {1'b0, ovr_set && !set_legal}
          + {1'b0, ovr_clr && !clr_legal};
    err_sum     = {1'b0, err_cnt} + {7'b0, n_err};
    nxt_err_cnt = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // State registers: entries, override state, read port and error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the entry array is reset along with the control flops because every
      // entry must read back as zero straight out of reset; this keeps it in flops
      // rather than an SRAM macro.
      storage  <= '{default: '0};
      ovr_bit  <= '{default: 1'b0};
      ovr_val  <= '{default: '0};
      rd_data  <= '0;
      rd_ovr   <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values computed above, independent of statement order.
      storage  <= nxt_storage;
      ovr_bit  <= nxt_ovr_bit;
      ovr_val  <= nxt_ovr_val;
      rd_data  <= nxt_rd_data;
      rd_ovr   <= nxt_rd_ovr;
      err_cnt  <= nxt_err_cnt;
      if (n_err != 2'd0) err_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_guarded_array_rf.sv
// Scoreboard bench for guarded_array_rf (WIDTH=2, DEPTH=2, BASE=1, IDX_W=4).
// A driver issues one transaction per cycle on the falling edge, updates a
// behavioural model and queues the expected outputs; a monitor compares the DUT
// outputs shortly after each rising edge against the head of the queue.
module tb_guarded_array_rf;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [1:0] wr_data;
  logic       ovr_set;
  logic       ovr_clr;
  logic [3:0] ovr_idx;
  logic [1:0] ovr_data;
  logic [3:0] rd_idx;
  logic [1:0] rd_data;
  logic       rd_ovr;
  logic       err_flag;
  logic [7:0] err_cnt;

  guarded_array_rf #(.WIDTH(2), .DEPTH(2), .BASE(1), .IDX_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .ovr_set  (ovr_set),
    .ovr_clr  (ovr_clr),
    .ovr_idx  (ovr_idx),
    .ovr_data (ovr_data),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rd_ovr   (rd_ovr),
    .err_flag (err_flag),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rd;
    logic       ovr;
    logic       flag;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: entry value, override flag and override value per index.
  int m_val   [2];
  int m_ob    [2];
  int m_ov    [2];
  int m_cnt;
  bit m_flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [3:0] idx);
`ifdef GUARDED_RF_XCHECK_EN
    if ($isunknown(idx)) return 1'b0;
`endif
    return (idx >= 4'd1) && (idx <= 4'd2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0;
      m_ob[i]  = 0;
      m_ov[i]  = 0;
    end
    m_cnt  = 0;
    m_flag = 0;
  endtask

  task automatic set_idle();
    wr_en = 0; wr_idx = 4'd1; wr_data = 0;
    ovr_set = 0; ovr_clr = 0; ovr_idx = 4'd1; ovr_data = 0;
    rd_idx = 4'd1;
  endtask

  // One transaction: drive on the falling edge, apply the rules to the model,
  // queue what the outputs must show after the next rising edge.
  task automatic cycle(input bit we, input logic [3:0] wi, input logic [1:0] wd,
                       input bit os, input bit oc, input logic [3:0] oi,
                       input logic [1:0] od, input logic [3:0] ri);
    exp_t e;
    int   errs;
    @(negedge clk);
    wr_en = we; wr_idx = wi; wr_data = wd;
    ovr_set = os; ovr_clr = oc; ovr_idx = oi; ovr_data = od;
    rd_idx = ri;

    errs = 0;
    if (os) begin
      if (m_legal(oi)) begin
        m_ob[int'(oi) - 1] = 1;
        m_ov[int'(oi) - 1] = int'(od);
      end else errs++;
    end
    if (oc) begin
      if (!m_legal(oi)) errs++;
      else if (!os) begin
        m_ob[int'(oi) - 1]  = 0;
        m_val[int'(oi) - 1] = m_ov[int'(oi) - 1];
      end
    end
    if (we) begin
      if (m_legal(wi)) m_val[int'(wi) - 1] = int'(wd);
      else errs++;
    end
    m_cnt = (m_cnt + errs > 255) ? 255 : m_cnt + errs;
    if (errs > 0) m_flag = 1;

    if (m_legal(ri)) begin
      e.ovr = m_ob[int'(ri) - 1] != 0;
      e.rd  = 2'(e.ovr ? m_ov[int'(ri) - 1] : m_val[int'(ri) - 1]);
    end else begin
      e.ovr = 1'b0;
      e.rd  = 2'd0;
    end
    e.flag = m_flag;
    e.cnt  = 8'(m_cnt);
    q.push_back(e);
  endtask

  task automatic rd(input logic [3:0] ri);
    cycle(0, 4'd1, 2'd0, 0, 0, 4'd1, 2'd0, ri);
  endtask

  // Monitor: outputs are valid every cycle; compare after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rd_data",  32'(rd_data),  32'(e.rd));
        check("rd_ovr",   32'(rd_ovr),   32'(e.ovr));
        check("err_flag", 32'(err_flag), 32'(e.flag));
        check("err_cnt",  32'(err_cnt),  32'(e.cnt));
      end
    end
  end

  // Wait, with a bound, for the monitor to consume every queued expectation.
  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic reset_mid();
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    set_idle();
    #1;
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_rd_ovr",   32'(rd_ovr),   32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_cnt",  32'(err_cnt),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_rd_data",  32'(rd_data),  32'd0);
    check("init_rd_ovr",   32'(rd_ovr),   32'd0);
    check("init_err_flag", 32'(err_flag), 32'd0);
    check("init_err_cnt",  32'(err_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal write leaves legal entries alone and is counted.
    cycle(1, 4'd1, 2'd0, 0, 0, 4'd1, 2'd0, 4'd1);
    cycle(1, 4'd2, 2'd0, 0, 0, 4'd1, 2'd0, 4'd2);
    cycle(1, 4'd0, 2'd1, 0, 0, 4'd1, 2'd0, 4'd1);
    rd(4'd2);
    rd(4'd0);

    // Override masks writes; clear copies the override value into the entry.
    cycle(0, 4'd1, 2'd0, 1, 0, 4'd2, 2'd3, 4'd2);
    cycle(1, 4'd2, 2'd1, 0, 0, 4'd1, 2'd0, 4'd2);
    cycle(0, 4'd1, 2'd0, 0, 1, 4'd2, 2'd0, 4'd2);
    cycle(1, 4'd2, 2'd2, 0, 0, 4'd1, 2'd0, 4'd2);

    // Simultaneous set and clear on one index resolves as set.
    cycle(0, 4'd1, 2'd0, 1, 1, 4'd1, 2'd2, 4'd1);

    // Write and clear hitting the same entry: the write data wins.
    cycle(1, 4'd1, 2'd1, 0, 1, 4'd1, 2'd0, 4'd1);

`ifdef GUARDED_RF_XCHECK_EN
    // Unknown index is illegal: no override, counted once.
    cycle(0, 4'd1, 2'd0, 1, 0, 4'bxxxx, 2'd1, 4'd2);
    rd(4'd1);
    rd(4'bxxxx);
`endif

    // Randomized traffic including out-of-range indices 0, 3 and 4.
    repeat (300) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)), 2'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 4)), 2'($urandom), 4'($urandom_range(0, 4)));
    end

    // Saturation: climb to 254 from a clean reset, then a triple error cycle.
    reset_mid();
    repeat (84) cycle(1, 4'd3, 2'd1, 1, 1, 4'd3, 2'd1, 4'd1);
    cycle(1, 4'd0, 2'd1, 1, 0, 4'd4, 2'd1, 4'd1);
    cycle(1, 4'd3, 2'd1, 1, 1, 4'd3, 2'd1, 4'd1);
    cycle(1, 4'd3, 2'd1, 1, 1, 4'd3, 2'd1, 4'd1);

    // Reset while an override is active.
    cycle(0, 4'd1, 2'd0, 1, 0, 4'd1, 2'd3, 4'd1);
    reset_mid();
    rd(4'd1);
    rd(4'd2);

    // More randomized traffic after reset.
    repeat (200) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)), 2'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 4)), 2'($urandom), 4'($urandom_range(0, 4)));
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
